seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Receive-side counterpart of the board's 7-segment digit encoder.
- Samples an external 7-segment bus, for example another board's HEX0 lines wired to GPIO, and filters glitches and transitions by requiring a stable pattern.
- Decodes each stable pattern back to a BCD digit.
- Reports digit changes as one-cycle pulses and rejects illegal patterns with an error flag and a counter.

Parameters:
- STABLE_CYCLES, 16, consecutive identical synchronized samples needed before a pattern is accepted; legal range 1..65535.
- ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (board convention); 0 = bus is inverted before decoding.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_in  in  7  raw segment bus, bit0 = segment a … bit6 = segment g; asynchronous to clk
- digit  out  4  last accepted digit, 0..9
- digit_valid  out  1  high while the last accepted pattern was a legal digit
- blank  out  1  high while the last accepted pattern was all segments off
- new_digit  out  1  one-cycle pulse when an accepted legal digit differs from the previous digit, or when digit_valid was low before
- bad_pattern  out  1  one-cycle pulse when an accepted pattern is neither a digit nor blank
- err_count  out  ERR_W  saturating count of bad_pattern pulses

Behaviour:
- Reset (async assert, sync release):
  - sync stages, candidate and committed pattern registers = blank code (7'h7F active-low).
  - cnt = 0, state = LOCKED.
  - digit = 0, digit_valid = 0, blank = 1, new_digit = 0, bad_pattern = 0, err_count = 0.
- Input path:
  - seg_in passes through a 2-flop synchronizer to give seg_s, with no logic between the flops.
  - If ACTIVE_LOW = 0, seg_s is inverted after the synchronizer.
- Legal codes (active-low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- FSM has two states, LOCKED and SETTLE.
  - LOCKED:
    - seg_s == cand: hold.
    - seg_s != cand: cand <= seg_s, cnt <= 1, go to SETTLE.
  - SETTLE:
    - seg_s != cand: cand <= seg_s, cnt <= 1 (restart; stay in SETTLE).
    - seg_s == cand and cnt < STABLE_CYCLES: cnt++.
    - seg_s == cand and cnt == STABLE_CYCLES: commit, go to LOCKED.
  - With STABLE_CYCLES = 1, the commit happens on the first matching cycle after cand loads.
- Commit (registered; effective on the commit edge):
  - Digit pattern:
    - digit <= value, digit_valid <= 1, blank <= 0.
    - new_digit <= 1 if value != previous digit or previous digit_valid == 0.
  - Blank pattern: digit_valid <= 0, blank <= 1; digit keeps its old value.
  - Other pattern:
    - bad_pattern <= 1, digit_valid <= 0, blank <= 0; digit keeps its old value.
    - err_count++, saturating at all-ones.
- Pulses: new_digit and bad_pattern are high for exactly one cycle and cleared on the following edge.
- Re-acceptance: a pattern equal to the committed one that was interrupted by a glitch shorter than STABLE_CYCLES re-commits, but gives no new_digit because the value is unchanged.
- Latency: a clean step on seg_in held steady produces the commit edge STABLE_CYCLES+3 rising edges after the first edge that samples the new value. This is 2 sync edges + 1 load edge + STABLE_CYCLES count edges.
- cnt width: clog2(STABLE_CYCLES+1); it must never wrap.
- Reset mid-SETTLE discards the candidate; no pulse is emitted.

Decomposition:
- Shared package seg7_pkg:
  - SEG_0..SEG_9 and SEG_BLANK constants (active-low).
  - A seg_kind enum: DIGIT, BLANK, ILLEGAL.
  - The same package is used by the existing encoder.
- Sub-module seg7_decode: purely combinational; 7-bit pattern in, 4-bit value + seg_kind out.
- seg7_capture contains the synchronizer, the stability FSM and the output registers.

Test Plan (STABLE_CYCLES = 4, ACTIVE_LOW = 1):
- Reset, then drive seg_in = 1111001 -> new_digit pulses once at edge 7 after the change; digit = 1, digit_valid = 1, blank = 0.
- From 1, glitch seg_in to 0100100 for 3 cycles then back to 1111001 -> digit stays 1; no new_digit, no bad_pattern.
- Step 1 -> 9 (0010000) held -> single new_digit; digit = 9. Re-drive 0010000 after a 2-cycle blank glitch -> no pulse.
- Drive 0111111 held -> bad_pattern pulses once; digit_valid = 0, digit stays 9, err_count = 1. Repeat 300 illegal commits -> err_count = 255 and saturates.
- Drive 1111111 -> blank = 1, digit_valid = 0, no pulses. Then drive 1000000 -> new_digit, digit = 0.
- Assert rst_n low during SETTLE (cnt = 2) -> all outputs at reset values immediately. After release, a held pattern needs a full STABLE_CYCLES+3 edges to commit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by both the digit encoder and the
// capture/decoder path.
//   SEG_0..SEG_9, SEG_BLANK : active-low segment codes, bit0 = a .. bit6 = g
//   seg_kind_e              : classification of a segment pattern
//   cap_state_e             : stability FSM states of seg7_capture
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        DIGIT,
        BLANK,
        ILLEGAL
    } seg_kind_e;

    typedef enum logic {
        LOCKED,
        SETTLE
    } cap_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder.
//   pattern : active-low segment pattern, bit0 = a .. bit6 = g
//   value   : decoded BCD digit (0 when kind is not DIGIT)
//   kind    : DIGIT, BLANK or ILLEGAL
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output seg_kind_e  kind
);

    always_comb begin
        value = 4'd0;
        kind  = DIGIT;
        case (pattern)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: kind  = BLANK;
            default:   kind  = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Receive side of a 7-segment link: synchronizes an external segment bus,
// waits for a pattern to be stable, then decodes and reports it.
//   clk, rst_n  : clock, asynchronous active-low reset
//   seg_in      : raw segment bus (asynchronous to clk), bit0 = a .. bit6 = g
//   digit       : last accepted digit 0..9
//   digit_valid : last accepted pattern was a digit
//   blank       : last accepted pattern was all segments off
//   new_digit   : 1-cycle pulse on an accepted digit that differs from the
//                 previous one (or follows a non-digit)
//   bad_pattern : 1-cycle pulse on an accepted illegal pattern
//   err_count   : saturating count of bad_pattern pulses
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             blank,
    output logic             new_digit,
    output logic             bad_pattern,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned    CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    // Reset the raw flops so that the post-inversion sample is the blank code,
    // whichever bus polarity is in use.
    localparam logic [6:0]     SYNC_RST = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    // ---------------------------------------------------------------
    // 2-flop synchronizer, nothing between the flops
    // ---------------------------------------------------------------
    logic [6:0] sync1, sync2, seg_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
        end else begin
            sync1 <= seg_in;
            sync2 <= sync1;
        end
    end

    assign seg_s = ACTIVE_LOW ? sync2 : ~sync2;

    // ---------------------------------------------------------------
    // Stability FSM
    // ---------------------------------------------------------------
    cap_state_e       state, state_n;
    logic [6:0]       cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOCKED;
            cand  <= SEG_BLANK;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        commit  = 1'b0;
        if (seg_s != cand) begin
            // Any change, locked or mid-settle, (re)starts the count.
            cand_n  = seg_s;
            cnt_n   = CNT_W'(1);
            state_n = SETTLE;
        end else if (state == SETTLE) begin
            if (cnt < CNT_MAX) begin
                cnt_n = cnt + CNT_W'(1);
            end else begin
                commit  = 1'b1;
                state_n = LOCKED;
            end
        end
    end

    // ---------------------------------------------------------------
    // Decode and output registers
    // ---------------------------------------------------------------
    logic [3:0] dec_value;
    seg_kind_e  dec_kind;

    // cand equals seg_s on the commit cycle, and is a flop output.
    seg7_decode u_decode (
        .pattern (cand),
        .value   (dec_value),
        .kind    (dec_kind)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            blank       <= 1'b1;
            new_digit   <= 1'b0;
            bad_pattern <= 1'b0;
            err_count   <= '0;
        end else begin
            new_digit   <= 1'b0;
            bad_pattern <= 1'b0;
            if (commit) begin
                case (dec_kind)
                    DIGIT: begin
                        digit       <= dec_value;
                        digit_valid <= 1'b1;
                        blank       <= 1'b0;
                        new_digit   <= (dec_value != digit) || !digit_valid;
                    end
                    BLANK: begin
                        digit_valid <= 1'b0;
                        blank       <= 1'b1;
                    end
                    default: begin
                        digit_valid <= 1'b0;
                        blank       <= 1'b0;
                        bad_pattern <= 1'b1;
                        if (err_count != {ERR_W{1'b1}})
                            err_count <= err_count + ERR_W'(1);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

    localparam int STABLE = 4;
    localparam int ERR_MAX = 255;
    localparam int RUN_SAT = STABLE + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic [3:0] digit;
    logic       digit_valid, blank, new_digit, bad_pattern;
    logic [7:0] err_count;

    seg7_capture #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b1), .ERR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .digit       (digit),
        .digit_valid (digit_valid),
        .blank       (blank),
        .new_digit   (new_digit),
        .bad_pattern (bad_pattern),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int nd_seen = 0;
    int bad_seen = 0;

    // ------------------------------------------------------------
    // Behavioural model: seg_s is seg_in two samples late; a pattern is
    // accepted when it has been seen on STABLE+1 consecutive edges since it
    // last changed (the value present out of reset is never "new").
    // ------------------------------------------------------------
    typedef struct {
        logic [6:0] h1, h2, prev;
        int         run;
        int         digit;
        bit         valid, blank, nd, bad;
        int         err;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.h1 = 7'h7F; r.h2 = 7'h7F; r.prev = 7'h7F; r.run = RUN_SAT;
        r.digit = 0; r.valid = 0; r.blank = 1; r.nd = 0; r.bad = 0; r.err = 0;
        return r;
    endfunction

    function automatic int lookup(logic [6:0] p);
        logic [6:0] codes [10];
        codes = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        for (int i = 0; i < 10; i++) if (codes[i] == p) return i;
        return -1;
    endfunction

    function automatic mdl_t mdl_step(mdl_t c, logic [6:0] in);
        mdl_t n = c;
        logic [6:0] s = c.h2;
        int v;
        n.run  = (s == c.prev) ? ((c.run >= RUN_SAT) ? RUN_SAT : c.run + 1) : 1;
        n.prev = s;
        n.nd = 0; n.bad = 0;
        if (n.run == STABLE + 1) begin
            v = lookup(s);
            if (v >= 0) begin
                n.nd = (v != c.digit) || !c.valid;
                n.digit = v; n.valid = 1; n.blank = 0;
            end else if (s == 7'h7F) begin
                n.valid = 0; n.blank = 1;
            end else begin
                n.bad = 1; n.valid = 0; n.blank = 0;
                if (c.err < ERR_MAX) n.err = c.err + 1;
            end
        end
        n.h2 = c.h1;
        n.h1 = in;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mdl_reset();
        else        m <= mdl_step(m, seg_in);
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checks = checks + 6;
            if (int'(digit) != m.digit) begin failures++; $display("FAIL cyc digit dut=%0d exp=%0d t=%0t", digit, m.digit, $time); end
            if (digit_valid != m.valid) begin failures++; $display("FAIL cyc digit_valid dut=%0b exp=%0b t=%0t", digit_valid, m.valid, $time); end
            if (blank != m.blank) begin failures++; $display("FAIL cyc blank dut=%0b exp=%0b t=%0t", blank, m.blank, $time); end
            if (new_digit != m.nd) begin failures++; $display("FAIL cyc new_digit dut=%0b exp=%0b t=%0t", new_digit, m.nd, $time); end
            if (bad_pattern != m.bad) begin failures++; $display("FAIL cyc bad_pattern dut=%0b exp=%0b t=%0t", bad_pattern, m.bad, $time); end
            if (int'(err_count) != m.err) begin failures++; $display("FAIL cyc err_count dut=%0d exp=%0d t=%0t", err_count, m.err, $time); end
            if (new_digit) nd_seen++;
            if (bad_pattern) bad_seen++;
        end
    end

    // ------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic [6:0] p);
        @(negedge clk);
        seg_in = p;
    endtask

    task automatic hold(int n);
        repeat (n) @(negedge clk);
    endtask

    // Count rising edges (from the next one) until new_digit appears.
    task automatic edges_to_new_digit(output int e);
        e = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (new_digit) begin e = i; break; end
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_digit"}, int'(digit), 0);
        chk({tag, "_valid"}, int'(digit_valid), 0);
        chk({tag, "_blank"}, int'(blank), 1);
        chk({tag, "_new"}, int'(new_digit), 0);
        chk({tag, "_bad"}, int'(bad_pattern), 0);
        chk({tag, "_err"}, int'(err_count), 0);
    endtask

    initial begin
        int e, nd0, bad0;
        // Reset
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        hold(2);

        // 1: step to digit 1, commit at edge STABLE+3 = 7
        drive(7'b1111001);
        edges_to_new_digit(e);
        chk("lat_1", e, 7);
        hold(3);
        chk("d1_digit", int'(digit), 1);
        chk("d1_valid", int'(digit_valid), 1);
        chk("d1_blank", int'(blank), 0);
        chk("d1_pulses", nd_seen, 1);

        // 2: 3-cycle glitch to 2 is filtered; 1 re-commits silently
        nd0 = nd_seen; bad0 = bad_seen;
        drive(7'b0100100); hold(2);
        drive(7'b1111001); hold(12);
        chk("glitch_nd", nd_seen - nd0, 0);
        chk("glitch_bad", bad_seen - bad0, 0);
        chk("glitch_digit", int'(digit), 1);

        // 3: step 1 -> 9, then 2-cycle blank glitch
        nd0 = nd_seen;
        drive(7'b0010000); hold(12);
        chk("d9_nd", nd_seen - nd0, 1);
        chk("d9_digit", int'(digit), 9);
        nd0 = nd_seen; bad0 = bad_seen;
        drive(7'b1111111); hold(1);
        drive(7'b0010000); hold(12);
        chk("blankglitch_nd", nd_seen - nd0, 0);
        chk("blankglitch_bad", bad_seen - bad0, 0);
        chk("blankglitch_valid", int'(digit_valid), 1);

        // 4: illegal pattern, then saturate the error counter
        bad0 = bad_seen;
        drive(7'b0111111); hold(12);
        chk("bad_pulse", bad_seen - bad0, 1);
        chk("bad_valid", int'(digit_valid), 0);
        chk("bad_digit", int'(digit), 9);
        chk("bad_err", int'(err_count), 1);
        bad0 = bad_seen;
        for (int i = 0; i < 300; i++) begin
            drive((i % 2 == 0) ? 7'b1111110 : 7'b0111111);
            hold(8);
        end
        chk("sat_pulses", bad_seen - bad0, 300);
        chk("sat_err", int'(err_count), 255);

        // 5: blank, then digit 0
        nd0 = nd_seen; bad0 = bad_seen;
        drive(7'b1111111); hold(12);
        chk("blk_blank", int'(blank), 1);
        chk("blk_valid", int'(digit_valid), 0);
        chk("blk_nd", nd_seen - nd0, 0);
        chk("blk_bad", bad_seen - bad0, 0);
        drive(7'b1000000); hold(12);
        chk("d0_nd", nd_seen - nd0, 1);
        chk("d0_digit", int'(digit), 0);
        chk("d0_valid", int'(digit_valid), 1);

        // 6: reset while settling (cnt = 2 after the 4th edge)
        drive(7'b1111001);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        hold(2);
        chk_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        edges_to_new_digit(e);
        chk("lat_after_rst", e, 7);
        hold(2);
        chk("rst_d1_digit", int'(digit), 1);
        chk("rst_d1_valid", int'(digit_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
